// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: request-side controller in front of a 2**M x N single-port RAM.
// Read / write / clear-word / clear-all requests enter through a valid/ready
// handshake, are queued in an in-order FIFO and issued one per cycle on
// registered RAM pins. Read data comes back on a registered response port.
// Clear-all is expanded into a sweep that clears every address in turn.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_op/addr/wdata     00 read, 01 write, 10 clear word, 11 clear all
//   rsp_valid/rsp_data    one-cycle read response pulse, data held until next
//   busy                  queued work, sweep, or read still in flight
//   ram_cs/rw/clr/addr/wdata   registered RAM pin drive
//   ram_rdata             RAM data_out
//
// state | meaning
// IDLE  | FIFO empty, nothing driven to the RAM
// RUN   | FIFO head popped and issued every cycle
// SWEEP | clear-all in progress, pops suspended
module ram_req_ctrl #(
    parameter int N     = 32,
    parameter int M     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [M-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [N-1:0] rsp_data,
    output logic         busy,
    output logic         ram_cs,
    output logic         ram_rw,
    output logic         ram_clr,
    output logic [M-1:0] ram_addr,
    output logic [N-1:0] ram_wdata,
    input  logic [N-1:0] ram_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLRW  = 2'b10;
    localparam logic [1:0] OP_CLRA  = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWEEP = 2'd2} state_t;
    state_t state_q, state_d;

    logic [1:0]    fifo_op   [DEPTH];
    logic [M-1:0]  fifo_addr [DEPTH];
    logic [N-1:0]  fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          ready_en_q;
    logic          empty, full, push, pop;

    logic          ram_cs_q, ram_cs_d;
    logic          ram_rw_q, ram_rw_d;
    logic          ram_clr_q, ram_clr_d;
    logic [M-1:0]  ram_addr_q, ram_addr_d;
    logic [N-1:0]  ram_wdata_q, ram_wdata_d;
    logic [M-1:0]  sweep_q, sweep_d;
    logic          rd_issue;
    logic [1:0]    rd_v_q;
    logic          rsp_valid_q;
    logic [N-1:0]  rsp_data_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);
    // ready_en_q keeps req_ready low until the first edge after reset release
    assign req_ready = ready_en_q && !full;
    assign push = req_valid && req_ready;
    assign pop  = !empty && (state_q != SWEEP);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr_q]   <= req_op;
            fifo_addr[wr_ptr_q] <= req_addr;
            fifo_data[wr_ptr_q] <= req_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        ram_cs_d    = 1'b0;
        ram_rw_d    = 1'b0;
        ram_clr_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        sweep_d     = sweep_q;
        rd_issue    = 1'b0;
        unique case (state_q)
            IDLE, RUN: begin
                if (pop) begin
                    state_d    = RUN;
                    ram_cs_d   = 1'b1;
                    ram_addr_d = fifo_addr[rd_ptr_q];
                    case (fifo_op[rd_ptr_q])
                        OP_READ:  rd_issue = 1'b1;
                        OP_WRITE: begin
                            ram_rw_d    = 1'b1;
                            ram_wdata_d = fifo_data[rd_ptr_q];
                        end
                        OP_CLRW:  ram_clr_d = 1'b1;
                        OP_CLRA:  begin
                            // address 0 goes out on the pop edge, the counter
                            // continues from 1 and wrapping back to 0 marks the end
                            ram_clr_d  = 1'b1;
                            ram_addr_d = '0;
                            sweep_d    = M'(1);
                            state_d    = SWEEP;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (sweep_q != '0) begin
                    ram_cs_d   = 1'b1;
                    ram_clr_d  = 1'b1;
                    ram_addr_d = sweep_q;
                    sweep_d    = sweep_q + M'(1);
                end else begin
                    state_d = empty ? IDLE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ready_en_q  <= 1'b0;
            ram_cs_q    <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_clr_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            sweep_q     <= '0;
            rd_v_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            ram_cs_q    <= ram_cs_d;
            ram_rw_q    <= ram_rw_d;
            ram_clr_q   <= ram_clr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            sweep_q     <= sweep_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            // stage 0: read on the RAM pins, stage 1: RAM has latched the address
            rd_v_q      <= {rd_v_q[0], rd_issue};
            rsp_valid_q <= rd_v_q[1];
            if (rd_v_q[1]) rsp_data_q <= ram_rdata;
        end
    end

    assign busy      = !empty || (state_q == SWEEP) || (|rd_v_q) || rsp_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ram_cs    = ram_cs_q;
    assign ram_rw    = ram_rw_q;
    assign ram_clr   = ram_clr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Testbench for ram_req_ctrl with a behavioural 32x32 single-port RAM attached.
`timescale 1ns/1ps
module tb_ram_req_ctrl;
    localparam int N = 32;
    localparam int M = 5;
    localparam int DEPTH = 4;
    localparam logic [1:0] RD = 2'b00, WR = 2'b01, CW = 2'b10, CA = 2'b11;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = 2'b00;
    logic [M-1:0] req_addr = '0;
    logic [N-1:0] req_wdata = '0;
    logic         rsp_valid;
    logic [N-1:0] rsp_data;
    logic         busy;
    logic         ram_cs, ram_rw, ram_clr;
    logic [M-1:0] ram_addr;
    logic [N-1:0] ram_wdata;
    logic [N-1:0] ram_rdata;

    ram_req_ctrl #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .ram_cs(ram_cs), .ram_rw(ram_rw), .ram_clr(ram_clr),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: memory updates on the edge, read address latched, data_out combinational
    logic [N-1:0] mem [2**M];
    logic [M-1:0] raddr_q = '0;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_clr)     mem[ram_addr] <= '0;
            else if (ram_rw) mem[ram_addr] <= ram_wdata;
            else             raddr_q <= ram_addr;
        end
    end
    assign ram_rdata = mem[raddr_q];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] rsp_q [$];
    int           rsp_cyc [$];
    int           clr_cnt = 0;
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back(rsp_data);
            rsp_cyc.push_back(cyc);
        end
        if (ram_cs === 1'b1 && ram_clr === 1'b1) clr_cnt++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic [1:0] op, input logic [M-1:0] a, input logic [N-1:0] d,
                        output int acc_cyc, output bit waited);
        int t = 0;
        waited = 1'b0;
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        while (req_ready !== 1'b1 && t < 200) begin
            waited = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        if (req_ready !== 1'b1) check("push_ready_timeout", req_ready, 1'b1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (busy !== 1'b0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy !== 1'b0) check({tag, "_drain_timeout"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_ctl"}, {ram_cs, ram_rw, ram_clr}, 3'b000);
        check({tag, "_ram_addr"}, ram_addr, 0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", req_ready, 1'b1);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [M-1:0] addr;
        logic [N-1:0] wdata;
        logic [N-1:0] exp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        logic [N-1:0] exp_q [$];
        int acc, acc_rd, base, nowait, clr_base;
        bit w, seen_wait;
        logic [N-1:0] e;

        for (int i = 0; i < 2**M; i++) mem[i] = '0;

        tbl[0] = '{WR, 5'd7,  32'h12345678, 32'h0};
        tbl[1] = '{WR, 5'd8,  32'hCAFEF00D, 32'h0};
        tbl[2] = '{RD, 5'd7,  32'h0,        32'h12345678};
        tbl[3] = '{CW, 5'd7,  32'h0,        32'h0};
        tbl[4] = '{RD, 5'd7,  32'h0,        32'h00000000};
        tbl[5] = '{RD, 5'd8,  32'h0,        32'hCAFEF00D};
        tbl[6] = '{WR, 5'd31, 32'hFFFFFFFF, 32'h0};
        tbl[7] = '{RD, 5'd31, 32'h0,        32'hFFFFFFFF};
        tbl[8] = '{WR, 5'd0,  32'h00000001, 32'h0};
        tbl[9] = '{RD, 5'd0,  32'h0,        32'h00000001};

        // reset state
        #12;
        check_reset_outputs("rst");
        release_reset();

        // idle: no requests
        for (int i = 0; i < 10; i++) begin
            check("idle_cs_busy_ready", {ram_cs, busy, req_ready}, 3'b001);
            @(posedge clk); #1;
        end

        // write then back-to-back read, latency 3
        base = rsp_q.size();
        push(WR, 5'd3, 32'hDEADBEEF, acc, w);
        push(RD, 5'd3, 32'h0, acc_rd, w);
        wait_idle("lat");
        check("lat_count", rsp_q.size() - base, 1);
        if (rsp_q.size() > base) begin
            check("lat_data", rsp_q[base], 32'hDEADBEEF);
            check("lat_cycles", rsp_cyc[base] - acc_rd, 3);
        end

        // table of mixed ops including clear-word
        base = rsp_q.size();
        for (int i = 0; i < 10; i++) begin
            push(tbl[i].op, tbl[i].addr, tbl[i].wdata, acc, w);
            if (tbl[i].op == RD) exp_q.push_back(tbl[i].exp);
        end
        wait_idle("tbl");
        check("tbl_count", rsp_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < rsp_q.size()) check($sformatf("tbl_rd%0d", i), rsp_q[base+i], exp_q[i]);

        // fill all addresses, then 32 pipelined reads
        for (int a = 0; a < 32; a++) push(WR, 5'(a), 32'h01010101 * a, acc, w);
        base = rsp_q.size();
        for (int a = 0; a < 32; a++) push(RD, 5'(a), 32'h0, acc, w);
        wait_idle("fill");
        check("fill_count", rsp_q.size() - base, 32);
        if (rsp_q.size() >= base + 32) begin
            for (int a = 0; a < 32; a++) check($sformatf("fill_rd%0d", a), rsp_q[base+a], 32'h01010101 * a);
            check("fill_back_to_back", rsp_cyc[base+31] - rsp_cyc[base], 31);
        end

        // clear-all with 6 writes queued behind it
        clr_base = clr_cnt;
        push(CA, 5'd0, 32'h0, acc, w);
        nowait = 0;
        seen_wait = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(WR, 5'(2*i + 2), 32'hB0000000 | i, acc, w);
            if (w) seen_wait = 1'b1;
            if (!seen_wait) nowait++;
        end
        check("sweep_accepts_before_stall", nowait, 4);
        wait_idle("sweep");
        check("sweep_clr_cycles", clr_cnt - clr_base, 32);
        base = rsp_q.size();
        for (int a = 0; a < 32; a++) push(RD, 5'(a), 32'h0, acc, w);
        wait_idle("sweep_rd");
        check("sweep_rd_count", rsp_q.size() - base, 32);
        if (rsp_q.size() >= base + 32) begin
            for (int a = 0; a < 32; a++) begin
                e = (a % 2 == 0 && a >= 2 && a <= 12) ? (32'hB0000000 | ((a - 2) / 2)) : 32'h0;
                check($sformatf("sweep_rd%0d", a), rsp_q[base+a], e);
            end
        end

        // reset with a read in flight
        base = rsp_q.size();
        push(RD, 5'd5, 32'h0, acc, w);
        @(posedge clk); #1;
        check("inflight_cs_before_reset", ram_cs, 1'b1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_inflight");
        repeat (2) @(posedge clk);
        release_reset();
        repeat (4) @(posedge clk);
        #1;
        check("inflight_no_rsp", rsp_q.size() - base, 0);

        // reset in the middle of a sweep, at address 10
        for (int a = 0; a < 32; a++) push(WR, 5'(a), 32'h5A000000 | a, acc, w);
        push(CA, 5'd0, 32'h0, acc, w);
        for (int t = 0; t < 100 && !(ram_clr === 1'b1 && ram_addr === 5'd10); t++) begin
            @(posedge clk); #1;
        end
        check("sweep_reached_addr10", {ram_clr, ram_addr}, {1'b1, 5'd10});
        base = rsp_q.size();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_sweep");
        repeat (2) @(posedge clk);
        release_reset();
        check("rst_sweep_no_rsp", rsp_q.size() - base, 0);
        base = rsp_q.size();
        for (int a = 0; a < 32; a++) push(RD, 5'(a), 32'h0, acc, w);
        wait_idle("rst_sweep_rd");
        check("rst_sweep_rd_count", rsp_q.size() - base, 32);
        if (rsp_q.size() >= base + 32) begin
            for (int a = 0; a < 32; a++) begin
                e = (a < 10) ? 32'h0 : (32'h5A000000 | a);
                check($sformatf("rst_sweep_rd%0d", a), rsp_q[base+a], e);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
